// File: rtl/fetch_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
interface fetch_if;
  logic        imem_rd;
  logic [15:0] imem_addr;
  logic        imem_stall;
  logic        imem_done;
  logic [15:0] imem_data;

  modport master (
    output imem_rd,
    output imem_addr,
    input  imem_stall,
    input  imem_done,
    input  imem_data
  );

  modport slave (
    input  imem_rd,
    input  imem_addr,
    output imem_stall,
    output imem_done,
    output imem_data
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch-stage front end: owns the PC, issues single outstanding imem reads,
// holds the returned word until decode consumes it, handles redirects/HALT.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] NOP      = 16'h0800
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall_in,
  input  logic          redirect,
  input  logic [15:0]   redirect_pc,
  fetch_if.master       mem,
  output logic [15:0]   instruction,
  output logic [15:0]   pcAdd2,
  output logic          valid,
  output logic          fetch_stall
);

  localparam int unsigned W = 16;

  typedef enum logic [2:0] {
    S_REQ    = 3'd0,
    S_WAIT   = 3'd1,
    S_HOLD   = 3'd2,
    S_DRAIN  = 3'd3,
    S_HALTED = 3'd4
  } state_t;

  state_t         state, state_n;
  logic [W-1:0]   pc, pc_n;
  logic [W-1:0]   hold, hold_n;
  logic           accept;

  // A request is taken by memory only while it is driven and not stalled.
  assign accept = mem.imem_rd & ~mem.imem_stall;

  // State, PC and held-instruction registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_REQ;
      pc    <= RESET_PC;
      hold  <= NOP;
    end else begin
      state <= state_n;
      pc    <= pc_n;
      hold  <= hold_n;
    end
  end

  // Next-state logic; redirect outranks stall, consume and HALT detection.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    hold_n  = hold;
    unique case (state)
      S_REQ: begin
        if (redirect) begin
          pc_n    = redirect_pc;
          // An accepted request cannot be withdrawn; its reply must be drained.
          state_n = accept ? S_DRAIN : S_REQ;
        end else if (accept) begin
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          pc_n    = redirect_pc;
          state_n = mem.imem_done ? S_REQ : S_DRAIN;
        end else if (mem.imem_done) begin
          hold_n  = mem.imem_data;
          state_n = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_n    = redirect_pc;
          state_n = S_REQ;
        end else if (!stall_in) begin
          pc_n    = pc + W'(2);
          state_n = (hold[15:11] == 5'b00000) ? S_HALTED : S_REQ;
        end
      end
      S_DRAIN: begin
        if (redirect) begin
          pc_n = redirect_pc;
        end else if (mem.imem_done) begin
          state_n = S_REQ;
        end
      end
      S_HALTED: begin
        if (redirect) begin
          pc_n    = redirect_pc;
          state_n = S_REQ;
        end
      end
      default: begin
        state_n = S_REQ;
      end
    endcase
  end

  // Outputs depend only on state and registers (plus reset gating of the read).
  always_comb begin
    mem.imem_rd   = (state == S_REQ) & ~rst;
    mem.imem_addr = pc;
    pcAdd2        = pc + W'(2);
    valid         = (state == S_HOLD);
    instruction   = (state == S_HOLD) ? hold : NOP;
    fetch_stall   = (state == S_REQ) | (state == S_WAIT) | (state == S_DRAIN);
  end

endmodule
